// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg
// Description : ID/EX pipeline register for the RV32I 5-stage core. It holds
//               during load-use stalls and inserts a bubble on a taken-branch
//               flush. While holding, it picks up writeback-stage writes to
//               its source operands. It also counts stall and flush events
//               for performance debug.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              valid_ID,
    input  logic [XLEN-1:0]   PC_ID,
    input  logic [XLEN-1:0]   PC_4_ID,
    input  logic [XLEN-1:0]   U_imm_ID,
    input  logic [XLEN-1:0]   I_imm_ID,
    input  logic [XLEN-1:0]   rs1_data_ID,
    input  logic [XLEN-1:0]   rs2_data_ID,
    input  logic [4:0]        rs1_ID,
    input  logic [4:0]        rs2_ID,
    input  logic [4:0]        rd_ID,
    input  logic [3:0]        ALU_op_ID,
    input  logic [2:0]        RF_sel_ID,
    input  logic              we_reg_ID,
    input  logic              we_mem_ID,
    input  logic              is_load_ID,
    input  logic              is_branch_ID,

    input  logic              stall,
    input  logic              flush,

    input  logic [4:0]        rd_WB,
    input  logic              we_reg_WB,
    input  logic [XLEN-1:0]   data_WB,

    output logic              valid_EX,
    output logic [XLEN-1:0]   PC_EX,
    output logic [XLEN-1:0]   PC_4_EX,
    output logic [XLEN-1:0]   U_imm_EX,
    output logic [XLEN-1:0]   I_imm_EX,
    output logic [XLEN-1:0]   rs1_data_EX,
    output logic [XLEN-1:0]   rs2_data_EX,
    output logic [4:0]        rs1_EX,
    output logic [4:0]        rs2_EX,
    output logic [4:0]        rd_EX,
    output logic [3:0]        ALU_op_EX,
    output logic [2:0]        RF_sel_EX,
    output logic              we_reg_EX,
    output logic              we_mem_EX,
    output logic              is_load_EX,
    output logic              is_branch_EX,

    output logic              hold_ID,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] c_MODE_LOAD   = 2'd0;
    localparam logic [1:0] c_MODE_BUBBLE = 2'd1;
    localparam logic [1:0] c_MODE_HOLD   = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic              r_valid_EX;
    logic [XLEN-1:0]   r_PC_EX;
    logic [XLEN-1:0]   r_PC_4_EX;
    logic [XLEN-1:0]   r_U_imm_EX;
    logic [XLEN-1:0]   r_I_imm_EX;
    logic [XLEN-1:0]   r_rs1_data_EX;
    logic [XLEN-1:0]   r_rs2_data_EX;
    logic [4:0]        r_rs1_EX;
    logic [4:0]        r_rs2_EX;
    logic [4:0]        r_rd_EX;
    logic [3:0]        r_ALU_op_EX;
    logic [2:0]        r_RF_sel_EX;
    logic              r_we_reg_EX;
    logic              r_we_mem_EX;
    logic              r_is_load_EX;
    logic              r_is_branch_EX;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [1:0]        w_mode;
    logic              w_snoop_rs1;
    logic              w_snoop_rs2;
    logic              w_stall_evt;
    logic              w_flush_evt;

    // Stall outranks flush: a held EX instruction has not resolved its branch.
    always_comb begin
        w_mode = c_MODE_LOAD;
        if (stall) begin
            w_mode = c_MODE_HOLD;
        end else if (flush) begin
            w_mode = c_MODE_BUBBLE;
        end
    end

    assign w_snoop_rs1 = we_reg_WB && (rd_WB != 5'd0) && (rd_WB == r_rs1_EX);
    assign w_snoop_rs2 = we_reg_WB && (rd_WB != 5'd0) && (rd_WB == r_rs2_EX);
    assign w_stall_evt = stall && r_valid_EX;
    assign w_flush_evt = (w_mode == c_MODE_BUBBLE);

    // Control bits and register indices: cleared on bubble, gated by valid on load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_EX     <= 1'b0;
            r_we_reg_EX    <= 1'b0;
            r_we_mem_EX    <= 1'b0;
            r_is_load_EX   <= 1'b0;
            r_is_branch_EX <= 1'b0;
            r_rs1_EX       <= 5'd0;
            r_rs2_EX       <= 5'd0;
            r_rd_EX        <= 5'd0;
        end else begin
            case (w_mode)
                c_MODE_LOAD: begin
                    r_valid_EX     <= valid_ID;
                    r_we_reg_EX    <= valid_ID & we_reg_ID;
                    r_we_mem_EX    <= valid_ID & we_mem_ID;
                    r_is_load_EX   <= valid_ID & is_load_ID;
                    r_is_branch_EX <= valid_ID & is_branch_ID;
                    r_rs1_EX       <= rs1_ID;
                    r_rs2_EX       <= rs2_ID;
                    r_rd_EX        <= rd_ID;
                end
                c_MODE_BUBBLE: begin
                    r_valid_EX     <= 1'b0;
                    r_we_reg_EX    <= 1'b0;
                    r_we_mem_EX    <= 1'b0;
                    r_is_load_EX   <= 1'b0;
                    r_is_branch_EX <= 1'b0;
                    r_rs1_EX       <= 5'd0;
                    r_rs2_EX       <= 5'd0;
                    r_rd_EX        <= 5'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath fields only change on load; bubbles leave them as don't-care.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_PC_EX     <= '0;
            r_PC_4_EX   <= '0;
            r_U_imm_EX  <= '0;
            r_I_imm_EX  <= '0;
            r_ALU_op_EX <= 4'd0;
            r_RF_sel_EX <= 3'd0;
        end else if (w_mode == c_MODE_LOAD) begin
            r_PC_EX     <= PC_ID;
            r_PC_4_EX   <= PC_4_ID;
            r_U_imm_EX  <= U_imm_ID;
            r_I_imm_EX  <= I_imm_ID;
            r_ALU_op_EX <= ALU_op_ID;
            r_RF_sel_EX <= RF_sel_ID;
        end
    end

    // Operand data also refreshes from WB while holding so it cannot go stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs1_data_EX <= '0;
            r_rs2_data_EX <= '0;
        end else begin
            case (w_mode)
                c_MODE_LOAD: begin
                    r_rs1_data_EX <= rs1_data_ID;
                    r_rs2_data_EX <= rs2_data_ID;
                end
                c_MODE_HOLD: begin
                    if (w_snoop_rs1) begin
                        r_rs1_data_EX <= data_WB;
                    end
                    if (w_snoop_rs2) begin
                        r_rs2_data_EX <= data_WB;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hold_ID      = stall & rst;

    assign valid_EX     = r_valid_EX;
    assign PC_EX        = r_PC_EX;
    assign PC_4_EX      = r_PC_4_EX;
    assign U_imm_EX     = r_U_imm_EX;
    assign I_imm_EX     = r_I_imm_EX;
    assign rs1_data_EX  = r_rs1_data_EX;
    assign rs2_data_EX  = r_rs2_data_EX;
    assign rs1_EX       = r_rs1_EX;
    assign rs2_EX       = r_rs2_EX;
    assign rd_EX        = r_rd_EX;
    assign ALU_op_EX    = r_ALU_op_EX;
    assign RF_sel_EX    = r_RF_sel_EX;
    assign we_reg_EX    = r_we_reg_EX;
    assign we_mem_EX    = r_we_mem_EX;
    assign is_load_EX   = r_is_load_EX;
    assign is_branch_EX = r_is_branch_EX;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipeline_reg
// Description : Directed bench for id_ex_pipeline_reg (CNT_W=4 so that
//               counter saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipeline_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_ID;
    logic [XLEN-1:0]  PC_ID, PC_4_ID, U_imm_ID, I_imm_ID, rs1_data_ID, rs2_data_ID;
    logic [4:0]       rs1_ID, rs2_ID, rd_ID;
    logic [3:0]       ALU_op_ID;
    logic [2:0]       RF_sel_ID;
    logic             we_reg_ID, we_mem_ID, is_load_ID, is_branch_ID;
    logic             stall, flush;
    logic [4:0]       rd_WB;
    logic             we_reg_WB;
    logic [XLEN-1:0]  data_WB;

    logic             valid_EX;
    logic [XLEN-1:0]  PC_EX, PC_4_EX, U_imm_EX, I_imm_EX, rs1_data_EX, rs2_data_EX;
    logic [4:0]       rs1_EX, rs2_EX, rd_EX;
    logic [3:0]       ALU_op_EX;
    logic [2:0]       RF_sel_EX;
    logic             we_reg_EX, we_mem_EX, is_load_EX, is_branch_EX;
    logic             hold_ID;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .valid_ID(valid_ID), .PC_ID(PC_ID), .PC_4_ID(PC_4_ID),
        .U_imm_ID(U_imm_ID), .I_imm_ID(I_imm_ID),
        .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .ALU_op_ID(ALU_op_ID), .RF_sel_ID(RF_sel_ID),
        .we_reg_ID(we_reg_ID), .we_mem_ID(we_mem_ID),
        .is_load_ID(is_load_ID), .is_branch_ID(is_branch_ID),
        .stall(stall), .flush(flush),
        .rd_WB(rd_WB), .we_reg_WB(we_reg_WB), .data_WB(data_WB),
        .valid_EX(valid_EX), .PC_EX(PC_EX), .PC_4_EX(PC_4_EX),
        .U_imm_EX(U_imm_EX), .I_imm_EX(I_imm_EX),
        .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .ALU_op_EX(ALU_op_EX), .RF_sel_EX(RF_sel_EX),
        .we_reg_EX(we_reg_EX), .we_mem_EX(we_mem_EX),
        .is_load_EX(is_load_EX), .is_branch_EX(is_branch_EX),
        .hold_ID(hold_ID), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge to sample and drive.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [31:0] d1, input logic [4:0] rs2,
                            input logic [31:0] d2, input logic [4:0] rd, input logic wr);
        valid_ID    = v;
        PC_ID       = pc;
        PC_4_ID     = pc + 32'd4;
        U_imm_ID    = pc ^ 32'h5A5A_0000;
        I_imm_ID    = {27'd0, rd};
        rs1_ID      = rs1;
        rs1_data_ID = d1;
        rs2_ID      = rs2;
        rs2_data_ID = d2;
        rd_ID       = rd;
        ALU_op_ID   = 4'hA;
        RF_sel_ID   = 3'd5;
        we_reg_ID   = wr;
        we_mem_ID   = 1'b1;
        is_load_ID  = 1'b1;
        is_branch_ID = 1'b1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rd_WB = 5'd0; we_reg_WB = 1'b0; data_WB = '0;
        drive_id(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0);

        // Reset asserted without a clock edge
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, valid_EX}, 32'd0);
        chk("rst_rd", {27'd0, rd_EX}, 32'd0);
        chk("rst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
        chk("rst_hold", {31'd0, hold_ID}, 32'd0);

        // Pass-through
        @(negedge clk);
        rst = 1'b1;
        drive_id(1'b1, 32'h100, 5'd1, 32'h1234, 5'd2, 32'h2222, 5'd5, 1'b1);
        step();
        chk("pt_rd", {27'd0, rd_EX}, 32'd5);
        chk("pt_rs1_data", rs1_data_EX, 32'h1234);
        chk("pt_valid_we", {30'd0, valid_EX, we_reg_EX}, 32'd3);
        chk("pt_pc", PC_EX, 32'h100);
        chk("pt_pc4", PC_4_EX, 32'h104);
        chk("pt_ctrl", {24'd0, ALU_op_EX, RF_sel_EX, we_mem_EX}, {24'd0, 4'hA, 3'd5, 1'b1});

        // WB write matching rs1_ID during LOAD is not snooped
        drive_id(1'b1, 32'h200, 5'd7, 32'hAAAA, 5'd7, 32'h5555, 5'd3, 1'b1);
        we_reg_WB = 1'b1; rd_WB = 5'd7; data_WB = 32'hDEAD;
        step();
        chk("load_no_snoop_rs1", rs1_data_EX, 32'hAAAA);
        chk("load_no_snoop_rs2", rs2_data_EX, 32'h5555);

        // Stall with snoop; rs1_EX == rs2_EX so both operands update
        drive_id(1'b1, 32'h300, 5'd9, 32'h9999, 5'd10, 32'h1010, 5'd11, 1'b0);
        stall = 1'b1; data_WB = 32'hBEEF;
        #1;
        chk("hold_id_comb", {31'd0, hold_ID}, 32'd1);
        step();
        chk("snoop_rs1", rs1_data_EX, 32'hBEEF);
        chk("snoop_rs2", rs2_data_EX, 32'hBEEF);
        chk("stall_keep_pc", PC_EX, 32'h200);
        chk("stall_keep_rd", {27'd0, rd_EX}, 32'd3);
        chk("stall_keep_we", {31'd0, we_reg_EX}, 32'd1);
        chk("stall_cnt_1", {28'd0, stall_cnt}, 32'd1);

        // Snoop to x0 is ignored
        rd_WB = 5'd0; data_WB = 32'h1111;
        step();
        chk("snoop_x0", rs1_data_EX, 32'hBEEF);
        chk("stall_cnt_2", {28'd0, stall_cnt}, 32'd2);

        // Stall beats flush
        we_reg_WB = 1'b0; flush = 1'b1;
        step();
        chk("sf_valid", {31'd0, valid_EX}, 32'd1);
        chk("sf_rd", {27'd0, rd_EX}, 32'd3);
        chk("sf_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        chk("sf_stall_cnt", {28'd0, stall_cnt}, 32'd3);

        // Flush inserts a bubble
        stall = 1'b0;
        step();
        chk("fl_valid_we", {30'd0, valid_EX, we_reg_EX}, 32'd0);
        chk("fl_ctrl", {29'd0, we_mem_EX, is_load_EX, is_branch_EX}, 32'd0);
        chk("fl_idx", {17'd0, rd_EX, rs1_EX, rs2_EX}, 32'd0);
        chk("fl_flush_cnt", {28'd0, flush_cnt}, 32'd1);

        // LOAD of an invalid slot gates side-effect controls
        flush = 1'b0;
        drive_id(1'b0, 32'h400, 5'd4, 32'h4444, 5'd6, 32'h6666, 5'd8, 1'b1);
        step();
        chk("inv_valid", {31'd0, valid_EX}, 32'd0);
        chk("inv_ctrl", {28'd0, we_reg_EX, we_mem_EX, is_load_EX, is_branch_EX}, 32'd0);
        chk("inv_rd", {27'd0, rd_EX}, 32'd8);

        // Stall with valid_EX=0 does not count
        stall = 1'b1;
        step();
        chk("stall_invalid_cnt", {28'd0, stall_cnt}, 32'd3);

        // Saturation: 20 counted stall cycles on a 4-bit counter
        stall = 1'b0;
        drive_id(1'b1, 32'h500, 5'd12, 32'hC0C0, 5'd13, 32'hD0D0, 5'd14, 1'b1);
        step();
        stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
        chk("sat_keep_pc", PC_EX, 32'h500);

        // Reset mid-stall discards the held instruction
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, valid_EX}, 32'd0);
        chk("rst_mid_data", rs1_data_EX, 32'd0);
        chk("rst_mid_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
        chk("rst_mid_hold", {31'd0, hold_ID}, 32'd0);
        @(negedge clk);
        rst = 1'b1; stall = 1'b0;
        drive_id(1'b1, 32'h600, 5'd15, 32'hF00D, 5'd16, 32'h0, 5'd17, 1'b1);
        step();
        chk("post_rst_load", {31'd0, valid_EX}, 32'd1);
        chk("post_rst_data", rs1_data_EX, 32'hF00D);
        chk("post_rst_rd", {27'd0, rd_EX}, 32'd17);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
